// File: rtl/anubis_pkg.sv
// rtl/anubis_pkg.sv - shared state encoding, command fields and word helper for the Anubis stream controller
package anubis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_CORE_RST  = 3'd3,
        ST_CORE_RUN  = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_SEND      = 3'd6
    } state_e;

    localparam int CMD_ENC_BIT     = 0;
    localparam int CMD_KEY_BIT     = 1;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

    // Big-endian word select: index 0 is bits [127:96].
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/anubis_word_pack.sv
// rtl/anubis_word_pack.sv - 32->128 shift-in register with 2-bit word count and block-full pulse
import anubis_pkg::*;

module anubis_word_pack (
    input  logic                clk,
    input  logic                reset,
    input  logic                word_valid_i,
    input  logic [WORD_W-1:0]   word_i,
    output logic [BLOCK_W-1:0]  block_o,
    output logic                full_o
);

    logic [BLOCK_W-1:0] block_q;
    logic [1:0]         cnt_q;

    // Shifting left puts the first word of a block in the top lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            block_q <= '0;
            cnt_q   <= 2'd0;
        end else if (word_valid_i) begin
            block_q <= {block_q[BLOCK_W-WORD_W-1:0], word_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign block_o = block_q;
    assign full_o  = word_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/anubis_stream_ctrl.sv
// rtl/anubis_stream_ctrl.sv - word-stream front/back end for the Anubis core; ANUBIS_WATCHDOG_EN adds a CORE_RUN timeout
import anubis_pkg::*;

module anubis_stream_ctrl #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [31:0]         m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                busy,
    output logic                error,
    output logic                core_reset,
    output logic                core_encrypt,
    output logic [127:0]        core_plain_text,
    output logic [127:0]        core_key,
    input  logic [127:0]        core_cipher_text,
    input  logic                core_end_flag
);

    localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    state_e                 state_q, state_d;
    logic                   enc_q, enc_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   stale_q, stale_d;
    logic [1:0]             idx_q, idx_d;
    logic [127:0]           cipher_q, cipher_d;

    logic                   s_fire;
    logic                   key_full, data_full;
    logic                   end_hit;
    logic                   timeout;
    logic [127:0]           key_blk, data_blk;

    assign s_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_LOAD_KEY) ||
                                (state_q == ST_LOAD_DATA));
    assign s_fire  = s_valid && s_ready;

    anubis_word_pack u_key_pack (
        .clk          (clk),
        .reset        (reset),
        .word_valid_i (s_fire && (state_q == ST_LOAD_KEY)),
        .word_i       (s_data),
        .block_o      (key_blk),
        .full_o       (key_full)
    );

    anubis_word_pack u_data_pack (
        .clk          (clk),
        .reset        (reset),
        .word_valid_i (s_fire && (state_q == ST_LOAD_DATA)),
        .word_i       (s_data),
        .block_o      (data_blk),
        .full_o       (data_full)
    );

    // The first CORE_RUN cycle may still show end_flag from the previous block.
    assign end_hit = !stale_q && core_end_flag;

`ifdef ANUBIS_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        error_q;

    assign timeout = (state_q == ST_CORE_RUN) && !end_hit &&
                     (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= 32'd0;
            error_q  <= 1'b0;
        end else if (state_q == ST_CORE_RUN) begin
            wd_cnt_q <= timeout ? 32'd0 : wd_cnt_q + 32'd1;
            if (timeout) begin
                error_q <= 1'b1;
            end
        end else begin
            wd_cnt_q <= 32'd0;
        end
    end

    assign error = error_q;
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            enc_q     <= 1'b1;
            rst_cnt_q <= '0;
            stale_q   <= 1'b0;
            idx_q     <= 2'd0;
            cipher_q  <= '0;
        end else begin
            state_q   <= state_d;
            enc_q     <= enc_d;
            rst_cnt_q <= rst_cnt_d;
            stale_q   <= stale_d;
            idx_q     <= idx_d;
            cipher_q  <= cipher_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enc_d     = enc_q;
        rst_cnt_d = rst_cnt_q;
        stale_d   = stale_q;
        idx_d     = idx_q;
        cipher_d  = cipher_q;
        case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    enc_d   = s_data[CMD_ENC_BIT];
                    state_d = s_data[CMD_KEY_BIT] ? ST_LOAD_KEY : ST_LOAD_DATA;
                end
            end
            ST_LOAD_KEY: begin
                if (key_full) begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                if (data_full) begin
                    state_d   = ST_CORE_RST;
                    rst_cnt_d = '0;
                end
            end
            ST_CORE_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_CORE_RUN;
                    stale_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_CORE_RUN: begin
                stale_d = 1'b0;
                if (end_hit) begin
                    state_d = ST_SETTLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cipher_d = core_cipher_text;
                idx_d    = 2'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_valid         = (state_q == ST_SEND);
    assign m_last          = m_valid && (idx_q == 2'd3);
    assign m_data          = block_word(cipher_q, idx_q);
    assign busy            = (state_q != ST_IDLE);
    // The core is only released while it is computing or being sampled.
    assign core_reset      = !((state_q == ST_CORE_RUN) || (state_q == ST_SETTLE));
    assign core_encrypt    = enc_q;
    assign core_key        = key_blk;
    assign core_plain_text = data_blk;

endmodule

// File: tb/tb_anubis_stream_ctrl.sv
// tb/tb_anubis_stream_ctrl.sv - self-checking bench for anubis_stream_ctrl with a behavioural core stub
module tb_anubis_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         busy;
    logic         error;
    logic         core_reset;
    logic         core_encrypt;
    logic [127:0] core_plain_text;
    logic [127:0] core_key;
    logic [127:0] core_cipher_text;
    logic         core_end_flag;

    int checks   = 0;
    int failures = 0;

    logic [127:0] key_m = '0;
    logic         err_m = 1'b0;

    logic stub_hang = 1'b0;
    int   stub_cnt  = 0;
    int   run_total = 0;
    int   mv_total  = 0;

    always #5 clk = ~clk;

    anubis_stream_ctrl #(.RST_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last),
        .busy             (busy),
        .error            (error),
        .core_reset       (core_reset),
        .core_encrypt     (core_encrypt),
        .core_plain_text  (core_plain_text),
        .core_key         (core_key),
        .core_cipher_text (core_cipher_text),
        .core_end_flag    (core_end_flag)
    );

    // Core stub: end_flag rises 20 cycles after core_reset falls; cipher = plain ^ key.
    always_ff @(posedge clk) begin
        if (core_reset !== 1'b0) begin
            stub_cnt      <= 0;
            core_end_flag <= 1'b0;
        end else begin
            stub_cnt      <= stub_cnt + 1;
            core_end_flag <= !stub_hang && (stub_cnt + 1 >= 20);
        end
    end
    assign core_cipher_text = core_plain_text ^ core_key;

    always_ff @(posedge clk) begin
        if (core_reset === 1'b0) run_total <= run_total + 1;
        if (m_valid === 1'b1)    mv_total  <= mv_total + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        int n;
        if (gap) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_ready_bound", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic load_op(input logic [31:0] cmd, input logic [127:0] key,
                           input logic [127:0] data, input bit gap,
                           output logic [127:0] exp);
        logic [127:0] k;
        k = cmd[1] ? key : key_m;
        send_word(cmd, gap);
        if (cmd[1]) begin
            for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32], gap);
        end
        for (int i = 0; i < 4; i++) send_word(data[127-32*i -: 32], gap);
        key_m = k;
        check("core_key", core_key, k);
        check("core_plain", core_plain_text, data);
        check("core_encrypt", core_encrypt, cmd[0]);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        exp = data ^ k;
    endtask

    task automatic recv_block(input logic [127:0] exp, input int stall);
        int n;
        logic [31:0] w;
        m_ready = (stall > 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (m_valid !== 1'b1 && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) begin
                check("recv_valid_bound", m_valid, 1'b1);
                m_ready = 1'b0;
                return;
            end
            w = exp[127-32*i -: 32];
            if (i == 0 && stall > 0) begin
                for (int k = 0; k < stall; k++) begin
                    check("stall_valid", m_valid, 1'b1);
                    check("stall_data", m_data, w);
                    check("stall_s_ready", s_ready, 1'b0);
                    tick();
                end
                m_ready = 1'b1;
            end
            check("m_data", m_data, w);
            check("m_last", m_last, (i == 3));
            tick();
        end
        m_ready = 1'b0;
        check("end_busy", busy, 1'b0);
        check("end_m_valid", m_valid, 1'b0);
        check("end_error", error, err_m);
    endtask

    task automatic run_op(input logic [31:0] cmd, input logic [127:0] key,
                          input logic [127:0] data, input bit gap, input int stall);
        logic [127:0] exp;
        load_op(cmd, key, data, gap, exp);
        recv_block(exp, stall);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst_s_ready0", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_core_reset1", core_reset, 1'b1);
        check("rst_core_key", core_key, 128'd0);
        check("rst_core_plain", core_plain_text, 128'd0);
        check("rst_core_encrypt", core_encrypt, 1'b1);
        reset = 1'b0;
        key_m = '0;
        err_m = 1'b0;
    endtask

    localparam logic [127:0] KEY1 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] ONES = {128{1'b1}};

    initial begin
        logic [127:0] exp;
        logic [127:0] rk;
        logic [127:0] rd;
        logic [31:0]  rc;
        int           snap_run;
        int           snap_mv;
        int           n;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) tick();
        check("rst_m_data", m_data, 32'd0);
        do_reset();
        tick();

        // 1. Encrypt with a fresh key.
        run_op(32'h3, KEY1, ONES, 1'b0, 0);
        // 2. Reuse key, decrypt, zero data -> key words out.
        run_op(32'h0, '0, '0, 1'b0, 0);
        // 3. Back-pressure for 10 cycles on the first output word.
        run_op(32'h1, '0, 128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b0, 10);

        // 4. Reset in the middle of CORE_RUN, then a normal command.
        send_word(32'h3, 1'b0);
        for (int i = 0; i < 4; i++) send_word(KEY1[127-32*i -: 32], 1'b0);
        for (int i = 0; i < 4; i++) send_word(32'hA5A5A5A5, 1'b0);
        repeat (6) tick();
        check("run_core_reset", core_reset, 1'b0);
        check("run_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_core_reset", core_reset, 1'b1);
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_key", core_key, 128'd0);
        reset = 1'b0;
        key_m = '0;
        tick();
        run_op(32'h0, '0, ONES, 1'b0, 0);
        run_op(32'h3, KEY1, ONES, 1'b0, 0);

        // 5. Input gaps give the same result as case 1.
        run_op(32'h3, KEY1, ONES, 1'b1, 0);

        // Randomized commands, keys, data, gaps and stalls.
        for (int r = 0; r < 6; r++) begin
            rc = $urandom;
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            run_op(rc, rk, rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

`ifdef ANUBIS_WATCHDOG_EN
        // 6. Core never finishes: watchdog aborts after 64 CORE_RUN cycles.
        stub_hang = 1'b1;
        load_op(32'h3, KEY1, ONES, 1'b0, exp);
        snap_run = run_total;
        snap_mv  = mv_total;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        check("wd_busy", busy, 1'b0);
        check("wd_error", error, 1'b1);
        check("wd_core_reset", core_reset, 1'b1);
        check("wd_run_cycles", 128'(run_total - snap_run), 128'd64);
        check("wd_no_output", 128'(mv_total - snap_mv), 128'd0);
        err_m = 1'b1;
        stub_hang = 1'b0;
        tick();
        run_op(32'h1, '0, ONES, 1'b0, 0);
        check("wd_sticky", error, 1'b1);
        do_reset();
        tick();
        run_op(32'h3, KEY1, ONES, 1'b0, 0);
`else
        check("no_wd_error", error, 1'b0);
        exp = '0;
        snap_run = 0;
        snap_mv  = 0;
        n = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
